// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Parity frames are built only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, pulses bit_done on the last cycle.
// Held at zero while restart is high so a new frame starts on a clean period.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign bit_done = (cnt_q == LAST) && !restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int IW = cnt_width(DATA_BITS);
    localparam int SW = cnt_width(STOP_BITS);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == ST_IDLE),
        .bit_done(bit_done)
    );

    assign accept = tx_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_START;
                    shreg_d    = tx_data;
                    bit_idx_d  = '0;
                    stop_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d    = ST_IDLE;
                        stop_cnt_d = '0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so tx leads by no comb path.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        unique case (state_d)
            ST_START: tx_d = UART_START_LEVEL;
            ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = UART_IDLE_LEVEL;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, 8 data bits, 1 stop bit.
// Parity frames are checked when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int passed = 0;
    int total  = 0;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    // Entered one sample after the accepting edge; checks every cycle of
    // the frame and the idle state that follows it.
    task automatic frame_check(input logic [7:0] b, input int on_at,
                               input int off_at);
        logic [15:0] bits;
        int nb;
        nb = 1 + 8 + P + 1;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = b[i];
        if (P == 1) bits[9] = ^b;
        for (int k = 0; k < nb * CPB; k++) begin
            if (k == on_at) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
            end
            if (k == off_at) tx_valid = 1'b0;
            chk($sformatf("tx_%02h_c%0d", b, k), tx, bits[k/CPB]);
            if (k == 0) chk($sformatf("busy_%02h", b), tx_busy, 1'b1);
            if (k % CPB == 0)
                chk($sformatf("rdy_lo_%02h_c%0d", b, k), tx_ready, 1'b0);
            step();
        end
        chk($sformatf("rdy_end_%02h", b), tx_ready, 1'b1);
        chk($sformatf("idle_%02h", b), tx, 1'b1);
        chk($sformatf("busy_end_%02h", b), tx_busy, 1'b0);
    endtask

    initial begin
        // Reset held three cycles with tx_valid asserted
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_tx_%0d", i), tx, 1'b1);
            chk($sformatf("rst_rdy_%0d", i), tx_ready, 1'b0);
            chk($sformatf("rst_busy_%0d", i), tx_busy, 1'b0);
        end
        rst = 1'b0;
        step();
        chk("rel_rdy", tx_ready, 1'b1);
        chk("rel_tx", tx, 1'b1);
        chk("rel_busy", tx_busy, 1'b0);

        // 0x55 accepted on the next edge
        step();
        tx_valid = 1'b0;
        frame_check(8'h55, -1, -1);

        // Back-to-back 0xA3 then 0x0F, tx_valid held high
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        step();
        tx_data = 8'h0F;
        frame_check(8'hA3, -1, -1);
        step();
        tx_valid = 1'b0;
        frame_check(8'h0F, -1, -1);

        // Data changed after accept, 0xFF offered mid-frame then withdrawn
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h5A;
        frame_check(8'h96, 10, 30);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("no_dup_tx_%0d", i), tx, 1'b1);
            chk($sformatf("no_dup_busy_%0d", i), tx_busy, 1'b0);
        end

        // Reset at cycle 13 of a frame
        tx_data  = 8'hC6;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (13) step();
        rst = 1'b1;
        step();
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", tx_busy, 1'b0);
        chk("mid_rst_rdy", tx_ready, 1'b0);
        rst = 1'b0;
        step();
        chk("mid_rel_rdy", tx_ready, 1'b1);
        chk("mid_rel_tx", tx, 1'b1);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        frame_check(8'h3C, -1, -1);

`ifdef UART_TX_PARITY_EN
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        frame_check(8'h07, -1, -1);
        tx_data  = 8'h03;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        frame_check(8'h03, -1, -1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
